// File: rtl/tag_alloc_mc.sv
// ---------------------------------------------------------------------------
// tag_alloc_mc
//
// Multi-channel tag allocator for the PE-array front end. Each channel (one
// per PE row) accepts a tag through a valid/ready handshake and spreads it
// over the first Kq active columns, where Kq is kernel_size clamped to
// [1, NUM_COL]. Distribution is either a column-by-column shift (mode 0) or
// a single-cycle broadcast (mode 1). The channel then holds the tag until
// every active column reports a lock, clears it, and pulses tag_done.
//
// Optional feature macro: TAG_ALLOC_PERF_EN
//   When defined, each channel keeps a 16-bit saturating count of cycles
//   spent waiting for locks and exports it on wait_cycles.
//
// Ports:
//   clk           - clock, everything on the rising edge
//   rst           - synchronous active-high reset
//   mode          - 0 = shift, 1 = broadcast (sampled at accept)
//   kernel_size   - active column count K (sampled at accept)
//   stall         - freezes shift progress in all channels
//   flush         - per-channel synchronous abort (no done pulse)
//   tag_in        - tag offered per channel (0 means "no tag")
//   tag_in_valid  - per-channel offer
//   tag_in_ready  - per-channel accept (combinational)
//   tag_locks     - per-column "tag consumed" indication
//   tag_out       - tag presented to each PE (combinational)
//   tag_busy      - registered, channel not idle
//   tag_done      - registered, one-cycle completion pulse
//   wait_cycles   - per-channel wait counter (TAG_ALLOC_PERF_EN only)
// ---------------------------------------------------------------------------
module tag_alloc_mc #(
  parameter int NUM_COL = 8,
  parameter int NUM_CH  = 4,
  parameter int TAG_W   = $clog2(NUM_COL) + 1,
  parameter int KS_W    = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   mode,
  input  logic [KS_W-1:0]                        kernel_size,
  input  logic                                   stall,
  input  logic [NUM_CH-1:0]                      flush,
  input  logic [NUM_CH-1:0][TAG_W-1:0]           tag_in,
  input  logic [NUM_CH-1:0]                      tag_in_valid,
  output logic [NUM_CH-1:0]                      tag_in_ready,
  input  logic [NUM_CH-1:0][NUM_COL-1:0]         tag_locks,
  output logic [NUM_CH-1:0][NUM_COL-1:0][TAG_W-1:0] tag_out,
  output logic [NUM_CH-1:0]                      tag_busy,
  output logic [NUM_CH-1:0]                      tag_done
`ifdef TAG_ALLOC_PERF_EN
  ,
  output logic [NUM_CH-1:0][15:0]                wait_cycles
`endif
);

  // Wide enough to hold the value NUM_COL itself.
  localparam int KQ_W = $clog2(NUM_COL + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Clamped kernel size, shared by all channels since kernel_size is shared.
  logic [KQ_W-1:0] kq_in;

  always_comb begin
    if (kernel_size == '0) begin
      kq_in = KQ_W'(1);
    end else if (kernel_size > KS_W'(NUM_COL)) begin
      kq_in = KQ_W'(NUM_COL);
    end else begin
      kq_in = KQ_W'(kernel_size);
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch

    state_t                         state_q;
    state_t                         state_d;
    logic [KQ_W-1:0]                kq_q;
    logic [KQ_W-1:0]                cnt_q;
    logic [NUM_COL-1:0][TAG_W-1:0]  tag_q;
    logic [NUM_COL-1:0][TAG_W-1:0]  out_vec;
    logic [NUM_COL-1:0]             act_mask;
    logic                           ready;
    logic                           accept;
    logic                           all_locked;
    logic                           busy_q;
    logic                           done_q;

    // Columns below the latched Kq take part in distribution and locking.
    always_comb begin
      act_mask = '0;
      for (int j = 0; j < NUM_COL; j++) begin
        act_mask[j] = (KQ_W'(j) < kq_q);
      end
    end

    // Inactive columns are treated as already locked.
    assign all_locked = &(tag_locks[c] | ~act_mask);

    assign ready  = (state_q == ST_IDLE) && !flush[c];
    assign accept = tag_in_valid[c] && ready;

    // A column drops its tag as soon as it reports a lock, even before the
    // whole channel completes.
    always_comb begin
      out_vec = '0;
      for (int j = 0; j < NUM_COL; j++) begin
        if (act_mask[j] && (state_q != ST_IDLE) && !tag_locks[c][j]) begin
          out_vec[j] = tag_q[j];
        end
      end
    end

    always_comb begin
      state_d = state_q;
      if (flush[c]) begin
        state_d = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (tag_in_valid[c]) begin
              // A single active column needs no shifting.
              if (mode || (kq_in == KQ_W'(1))) begin
                state_d = ST_WAIT;
              end else begin
                state_d = ST_SHIFT;
              end
            end
          end
          ST_SHIFT: begin
            // cnt_q counts columns already holding the tag; the edge that
            // fills the last one moves on to WAIT.
            if (!stall && (cnt_q == kq_q - KQ_W'(1))) begin
              state_d = ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (all_locked) begin
              state_d = ST_IDLE;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end

    // Busy is registered from the next state so it rises on the accept edge
    // and falls on the exit edge.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        busy_q  <= (state_d != ST_IDLE);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        tag_q  <= '0;
        cnt_q  <= '0;
        kq_q   <= KQ_W'(1);
        done_q <= 1'b0;
      end else begin
        done_q <= 1'b0;
        if (flush[c]) begin
          tag_q <= '0;
          cnt_q <= '0;
        end else begin
          case (state_q)
            ST_IDLE: begin
              if (accept) begin
                kq_q  <= kq_in;
                cnt_q <= KQ_W'(1);
                tag_q <= '0;
                if (mode) begin
                  for (int j = 0; j < NUM_COL; j++) begin
                    if (KQ_W'(j) < kq_in) begin
                      tag_q[j] <= tag_in[c];
                    end
                  end
                end else begin
                  tag_q[0] <= tag_in[c];
                end
              end
            end
            ST_SHIFT: begin
              // Column 0 keeps its value so the tag is replicated rightward.
              if (!stall) begin
                for (int j = 1; j < NUM_COL; j++) begin
                  if (act_mask[j]) begin
                    tag_q[j] <= tag_q[j-1];
                  end
                end
                cnt_q <= cnt_q + KQ_W'(1);
              end
            end
            ST_WAIT: begin
              if (all_locked) begin
                tag_q  <= '0;
                done_q <= 1'b1;
              end
            end
            default: begin
              tag_q <= '0;
            end
          endcase
        end
      end
    end

`ifdef TAG_ALLOC_PERF_EN
    logic [15:0] wait_cnt_q;

    // Counts every edge spent in WAIT, including the completing one, and
    // keeps the last figure visible while idle.
    always_ff @(posedge clk) begin
      if (rst) begin
        wait_cnt_q <= '0;
      end else if (accept) begin
        wait_cnt_q <= '0;
      end else if ((state_q == ST_WAIT) && (wait_cnt_q != 16'hFFFF)) begin
        wait_cnt_q <= wait_cnt_q + 16'd1;
      end
    end

    assign wait_cycles[c] = wait_cnt_q;
`endif

    assign tag_in_ready[c] = ready;
    assign tag_out[c]      = out_vec;
    assign tag_busy[c]     = busy_q;
    assign tag_done[c]     = done_q;

  end

endmodule

// File: tb/tb_tag_alloc_mc.sv
// ---------------------------------------------------------------------------
// tb_tag_alloc_mc
//
// Self-checking bench for tag_alloc_mc. A behavioural model tracks, per
// channel, how many leading columns hold the tag and whether distribution
// has finished; every cycle all outputs are compared against it. A table of
// clamp/latency vectors and a few hand-written sequences cover the corner
// cases, then randomized traffic runs against the same model.
// ---------------------------------------------------------------------------
module tb_tag_alloc_mc;

  localparam int NUM_COL = 8;
  localparam int NUM_CH  = 4;
  localparam int TAG_W   = 4;
  localparam int KS_W    = 8;

  logic                                   clk = 1'b0;
  logic                                   rst;
  logic                                   mode;
  logic [KS_W-1:0]                        kernel_size;
  logic                                   stall;
  logic [NUM_CH-1:0]                      flush;
  logic [NUM_CH-1:0][TAG_W-1:0]           tag_in;
  logic [NUM_CH-1:0]                      tag_in_valid;
  logic [NUM_CH-1:0]                      tag_in_ready;
  logic [NUM_CH-1:0][NUM_COL-1:0]         tag_locks;
  logic [NUM_CH-1:0][NUM_COL-1:0][TAG_W-1:0] tag_out;
  logic [NUM_CH-1:0]                      tag_busy;
  logic [NUM_CH-1:0]                      tag_done;
`ifdef TAG_ALLOC_PERF_EN
  logic [NUM_CH-1:0][15:0]                wait_cycles;
`endif

  tag_alloc_mc #(
    .NUM_COL(NUM_COL),
    .NUM_CH (NUM_CH),
    .TAG_W  (TAG_W),
    .KS_W   (KS_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .kernel_size (kernel_size),
    .stall       (stall),
    .flush       (flush),
    .tag_in      (tag_in),
    .tag_in_valid(tag_in_valid),
    .tag_in_ready(tag_in_ready),
    .tag_locks   (tag_locks),
    .tag_out     (tag_out),
    .tag_busy    (tag_busy),
    .tag_done    (tag_done)
`ifdef TAG_ALLOC_PERF_EN
    ,
    .wait_cycles (wait_cycles)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model: per channel, busy flag, whether all Kq columns hold
  // the tag (waiting for locks), number of filled columns, Kq and the tag.
  bit               m_busy   [NUM_CH];
  bit               m_wait   [NUM_CH];
  int               m_filled [NUM_CH];
  int               m_kq     [NUM_CH];
  logic [TAG_W-1:0] m_tag    [NUM_CH];
  bit               m_done   [NUM_CH];
  int               m_perf   [NUM_CH];

  typedef struct {
    bit mode;
    int ks;
    int tag;
    int exp_cols;
    int exp_lat;
  } vec_t;

  vec_t vecs[8];

  function automatic int clampK(input int ks);
    if (ks == 0) return 1;
    if (ks > NUM_COL) return NUM_COL;
    return ks;
  endfunction

  function automatic bit allLocked(input int c);
    for (int j = 0; j < m_kq[c]; j++) begin
      if (!tag_locks[c][j]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Advance the model by one rising edge using the inputs driven before it.
  task automatic modelEdge();
    for (int c = 0; c < NUM_CH; c++) begin
      m_done[c] = 1'b0;
      if (rst) begin
        m_busy[c]   = 1'b0;
        m_wait[c]   = 1'b0;
        m_filled[c] = 0;
        m_kq[c]     = 1;
        m_tag[c]    = '0;
        m_perf[c]   = 0;
      end else begin
        if (m_busy[c] && m_wait[c] && m_perf[c] < 65535) m_perf[c]++;
        if (flush[c]) begin
          m_busy[c]   = 1'b0;
          m_wait[c]   = 1'b0;
          m_filled[c] = 0;
        end else if (!m_busy[c]) begin
          if (tag_in_valid[c]) begin
            m_busy[c] = 1'b1;
            m_kq[c]   = clampK(int'(kernel_size));
            m_tag[c]  = tag_in[c];
            m_perf[c] = 0;
            if (mode) begin
              m_filled[c] = m_kq[c];
              m_wait[c]   = 1'b1;
            end else begin
              m_filled[c] = 1;
              m_wait[c]   = (m_kq[c] == 1);
            end
          end
        end else if (!m_wait[c]) begin
          if (!stall) begin
            m_filled[c]++;
            if (m_filled[c] == m_kq[c]) m_wait[c] = 1'b1;
          end
        end else if (allLocked(c)) begin
          m_busy[c]   = 1'b0;
          m_wait[c]   = 1'b0;
          m_filled[c] = 0;
          m_done[c]   = 1'b1;
        end
      end
    end
  endtask

  task automatic checkVal(input string nm, input int c,
                          input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s ch%0d: got %0h expected %0h", nm, c, act, exp);
    end
  endtask

  // Compare every output of every channel against the model.
  task automatic checkOutput();
    logic [NUM_COL-1:0][TAG_W-1:0] ev;
    for (int c = 0; c < NUM_CH; c++) begin
      ev = '0;
      for (int j = 0; j < NUM_COL; j++) begin
        if (m_busy[c] && j < m_filled[c] && !tag_locks[c][j]) ev[j] = m_tag[c];
      end
      checkVal("ready",   c, 64'(tag_in_ready[c]), 64'(!m_busy[c] && !flush[c]));
      checkVal("busy",    c, 64'(tag_busy[c]),     64'(m_busy[c]));
      checkVal("done",    c, 64'(tag_done[c]),     64'(m_done[c]));
      checkVal("tag_out", c, 64'(tag_out[c]),      64'(ev));
`ifdef TAG_ALLOC_PERF_EN
      checkVal("wait_cycles", c, 64'(wait_cycles[c]), 64'(m_perf[c]));
`endif
    end
  endtask

  // One clock: let the DUT take the edge, step the model, then sample.
  task automatic applyStimulus();
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput();
  endtask

  initial begin
    int fill;
    int lat;
    int got;
    int n;
    int first;

    vecs[0] = '{1'b0,  3, 5, 3, 3};
    vecs[1] = '{1'b0,  0, 7, 1, 1};
    vecs[2] = '{1'b1,  0, 2, 1, 1};
    vecs[3] = '{1'b1, 12, 9, 8, 1};
    vecs[4] = '{1'b0,  8, 3, 8, 8};
    vecs[5] = '{1'b1,  5, 6, 5, 1};
    vecs[6] = '{1'b0, 20, 1, 8, 8};
    vecs[7] = '{1'b0,  2, 4, 2, 2};

    rst          = 1'b1;
    mode         = 1'b0;
    kernel_size  = '0;
    stall        = 1'b0;
    flush        = '0;
    tag_in       = '0;
    tag_in_valid = '0;
    tag_locks    = '0;

    // Reset state and first idle cycle.
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
    applyStimulus();

    // Clamp and latency vectors on channel 0; channel 1 stays idle.
    for (int i = 0; i < 8; i++) begin
      mode            = vecs[i].mode;
      kernel_size     = 8'(vecs[i].ks);
      tag_in[0]       = 4'(vecs[i].tag);
      tag_in_valid[0] = 1'b1;
      tag_locks       = '0;
      applyStimulus();
      tag_in_valid[0] = 1'b0;
      fill = vecs[i].mode ? 0 : vecs[i].exp_cols - 1;
      for (int k = 0; k < fill; k++) applyStimulus();
      n = 0;
      for (int j = 0; j < NUM_COL; j++) begin
        if (tag_out[0][j] == 4'(vecs[i].tag)) n++;
      end
      checkVal("fill_cols", 0, 64'(n), 64'(vecs[i].exp_cols));
      tag_locks[0] = '1;
      lat = fill;
      got = 0;
      for (int k = 0; k < 20 && got == 0; k++) begin
        applyStimulus();
        lat++;
        if (tag_done[0]) got = 1;
      end
      checkVal("done_lat", 0, 64'(got ? lat : 999), 64'(vecs[i].exp_lat));
      tag_locks = '0;
      applyStimulus();
    end

    // Stall for 3 edges mid-shift with K=4: column 3 arrives 3 edges late.
    mode            = 1'b0;
    kernel_size     = 8'd4;
    tag_in[0]       = 4'd6;
    tag_in_valid[0] = 1'b1;
    applyStimulus();
    tag_in_valid[0] = 1'b0;
    first = -1;
    for (int k = 1; k <= 10; k++) begin
      stall = (k >= 2 && k <= 4);
      applyStimulus();
      if (first < 0 && tag_out[0][3] != '0) first = k;
    end
    stall = 1'b0;
    checkVal("stall_col3", 0, 64'(first), 64'd6);
    tag_locks[0] = '1;
    applyStimulus();
    applyStimulus();
    tag_locks = '0;
    applyStimulus();

    // Flush in WAIT with all locks high: no done, channel returns idle.
    mode            = 1'b1;
    kernel_size     = 8'd5;
    tag_in[2]       = 4'd3;
    tag_in_valid[2] = 1'b1;
    applyStimulus();
    tag_in_valid[2] = 1'b0;
    flush[2]        = 1'b1;
    tag_locks[2]    = '1;
    applyStimulus();
    checkVal("flush_done", 2, 64'(tag_done[2]), 64'd0);
    checkVal("flush_busy", 2, 64'(tag_busy[2]), 64'd0);
    // Flush while valid is offered in IDLE: nothing accepted.
    tag_in_valid[2] = 1'b1;
    tag_locks[2]    = '0;
    applyStimulus();
    checkVal("flush_noacc", 2, 64'(tag_busy[2]), 64'd0);
    flush           = '0;
    tag_in_valid    = '0;
    applyStimulus();

    // Locks held low for 10 cycles in WAIT, then released.
    mode            = 1'b1;
    kernel_size     = 8'd8;
    tag_in[3]       = 4'd2;
    tag_in_valid[3] = 1'b1;
    applyStimulus();
    tag_in_valid[3] = 1'b0;
    for (int k = 0; k < 10; k++) applyStimulus();
    tag_locks[3] = '1;
    applyStimulus();
    checkVal("done_after_wait", 3, 64'(tag_done[3]), 64'd1);
`ifdef TAG_ALLOC_PERF_EN
    checkVal("wait_cycles_11", 3, 64'(wait_cycles[3]), 64'd11);
`endif
    tag_locks = '0;
    applyStimulus();

    // Reset mid-operation overrides flush and accept.
    mode            = 1'b0;
    kernel_size     = 8'd5;
    tag_in[1]       = 4'd9;
    tag_in_valid[1] = 1'b1;
    applyStimulus();
    tag_in_valid[1] = 1'b0;
    applyStimulus();
    applyStimulus();
    rst          = 1'b1;
    flush        = '1;
    tag_in_valid = '1;
    applyStimulus();
    rst          = 1'b0;
    flush        = '0;
    tag_in_valid = '0;
    applyStimulus();

    // Randomized traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      rst         = ($urandom_range(99) == 0);
      mode        = 1'($urandom_range(1));
      kernel_size = 8'($urandom_range(12));
      stall       = ($urandom_range(3) == 0);
      for (int c = 0; c < NUM_CH; c++) begin
        tag_in_valid[c] = 1'($urandom_range(1));
        flush[c]        = ($urandom_range(19) == 0);
        tag_in[c]       = 4'($urandom_range(15));
        for (int j = 0; j < NUM_COL; j++) begin
          tag_locks[c][j] = ($urandom_range(3) != 0);
        end
      end
      applyStimulus();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
